// File: rtl/spi_pkg.sv
// Shared definitions for the SPI link: frame width, counter sizing and the
// receiver FSM state encoding.
package spi_pkg;

   // Frame length shared with the SPI master (matches its din width).
   localparam int SPI_DATA_W = 12;

   // Bit counter must be able to hold the value SPI_DATA_W itself.
   localparam int SPI_CNT_W = $clog2(SPI_DATA_W + 1);

   // Receiver frame states.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } spi_rx_state_t;

endpackage : spi_pkg

// File: rtl/spi_sync.sv
// Single-bit multi-flop synchronizer with a configurable depth and reset
// value. STAGES must be at least 2.
module spi_sync #(
   parameter int   STAGES  = 2,
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] ff;

   // Shift the asynchronous input through the flop chain.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ff <= {STAGES{RST_VAL}};
      end else begin
         ff <= {ff[STAGES-2:0], d};
      end
   end

   assign q = ff[STAGES-1];

endmodule : spi_sync

// File: rtl/spi_slave_rx.sv
// SPI mode-0 slave receiver. Oversamples sclk/cs_n/mosi on the system clock,
// assembles one DATA_W-bit word per chip-select frame (MSB first) and offers
// it on a one-deep output register with overrun and short-frame flags.
//
// Output handshake: a word is transferred on a rising clk edge where
// dout_valid and dout_ready are both high. dout_valid never depends on
// dout_ready within the same cycle, and dout is stable while dout_valid is
// high and no transfer has happened.
module spi_slave_rx
   import spi_pkg::*;
#(
   parameter int DATA_W      = SPI_DATA_W,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sclk,
   input  logic              cs_n,
   input  logic              mosi,
   output logic [DATA_W-1:0] dout,
   output logic              dout_valid,
   input  logic              dout_ready,
   output logic              overrun,
   output logic              frame_err,
   output spi_rx_state_t     dbg_state
);

   localparam int                 CNT_W    = $clog2(DATA_W + 1);
   localparam logic [CNT_W-1:0]   CNT_FULL = CNT_W'(DATA_W);
   localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DATA_W - 1);

   // Synchronized inputs and their one-cycle delayed copies.
   logic sclk_s, cs_s, mosi_s;
   logic sclk_d, cs_d;
   logic sclk_rise, cs_fall, cs_rise;

   // Post-reset settle window: the cs synchronizer starts at its idle value,
   // so a falling edge seen before the chain has flushed may be an artefact
   // of reset rather than a real frame start.
   logic [SYNC_STAGES:0] arm_sr;
   logic                 armed;

   // Receiver FSM state.
   spi_rx_state_t     state;
   logic [DATA_W-1:0] sr;
   logic [CNT_W-1:0]  cnt;
   logic [DATA_W-1:0] word_q;
   logic              load_req;

   spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
      .clk (clk),
      .rst (rst),
      .d   (sclk),
      .q   (sclk_s)
   );

   spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
      .clk (clk),
      .rst (rst),
      .d   (cs_n),
      .q   (cs_s)
   );

   spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
      .clk (clk),
      .rst (rst),
      .d   (mosi),
      .q   (mosi_s)
   );

   // Delay flops for edge detection on the synchronized controls.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sclk_d <= 1'b0;
         cs_d   <= 1'b1;
      end else begin
         sclk_d <= sclk_s;
         cs_d   <= cs_s;
      end
   end

   // Arm frame detection only once the cs chain holds real samples.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         arm_sr <= '0;
      end else begin
         arm_sr <= {arm_sr[SYNC_STAGES-1:0], 1'b1};
      end
   end

   assign armed     = arm_sr[SYNC_STAGES];
   assign sclk_rise = sclk_s & ~sclk_d;
   assign cs_fall   = cs_d & ~cs_s;
   assign cs_rise   = ~cs_d & cs_s;

   // Frame FSM: shift bits on sclk rising edges and hand a completed word
   // to the output stage one cycle after the final sample.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         sr        <= '0;
         cnt       <= '0;
         word_q    <= '0;
         load_req  <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         load_req  <= 1'b0;
         frame_err <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (cs_fall && armed) begin
                  state <= ST_SHIFT;
                  sr    <= '0;
                  cnt   <= '0;
               end
            end
            ST_SHIFT: begin
               if (cnt == CNT_FULL) begin
                  // Word complete: capture it and request the load. If cs
                  // already rose (possibly together with the last sample),
                  // the frame is over and DONE would wait for nothing.
                  word_q   <= sr;
                  load_req <= 1'b1;
                  state    <= cs_s ? ST_IDLE : ST_DONE;
               end else if (sclk_rise) begin
                  // The sample is taken before a coincident cs rise is
                  // judged, so only a still-incomplete frame is an error.
                  sr  <= {sr[DATA_W-2:0], mosi_s};
                  cnt <= cnt + 1'b1;
                  if (cs_rise && (cnt != CNT_LAST)) begin
                     frame_err <= 1'b1;
                     state     <= ST_IDLE;
                  end
               end else if (cs_rise) begin
                  // An empty frame ends silently.
                  frame_err <= (cnt != '0);
                  state     <= ST_IDLE;
               end
            end
            ST_DONE: begin
               if (cs_rise) begin
                  state <= ST_IDLE;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   // One-deep output register: load when empty or when the held word is
   // leaving this same cycle; otherwise drop the new word and flag overrun.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dout       <= '0;
         dout_valid <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         overrun <= 1'b0;
         if (load_req) begin
            if (!dout_valid || dout_ready) begin
               dout       <= word_q;
               dout_valid <= 1'b1;
            end else begin
               overrun <= 1'b1;
            end
         end else if (dout_valid && dout_ready) begin
            dout_valid <= 1'b0;
         end
      end
   end

   assign dbg_state = state;

endmodule : spi_slave_rx

// File: tb/tb_spi_slave_rx.sv
// Bench for spi_slave_rx: directed scenarios followed by randomized frames,
// checked against a frame-level reference model of the receiver.
module tb_spi_slave_rx;
   import spi_pkg::*;

   localparam int DATA_W = 12;
   localparam int SYNC   = 2;
   localparam int HALF   = 4;   // sclk half-period in clk cycles

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst;
   logic sclk, cs_n, mosi, dout_ready;
   logic [DATA_W-1:0] dout;
   logic dout_valid, overrun, frame_err;
   spi_rx_state_t dbg_state;

   always #5 clk = ~clk;

   spi_slave_rx #(.DATA_W(DATA_W), .SYNC_STAGES(SYNC)) dut (
      .clk        (clk),
      .rst        (rst),
      .sclk       (sclk),
      .cs_n       (cs_n),
      .mosi       (mosi),
      .dout       (dout),
      .dout_valid (dout_valid),
      .dout_ready (dout_ready),
      .overrun    (overrun),
      .frame_err  (frame_err),
      .dbg_state  (dbg_state)
   );

   int checks = 0;
   int errors = 0;

   // ---------------- monitor ----------------
   logic [DATA_W-1:0] got_q[$];
   int mon_ovr  = 0;
   int mon_ferr = 0;

   always @(negedge clk) begin
      if (dout_valid && dout_ready) got_q.push_back(dout);
      if (overrun)   mon_ovr++;
      if (frame_err) mon_ferr++;
   end

   // ---------------- reference model ----------------
   // A frame of n bits yields a word (its first DATA_W bits) when n >= DATA_W,
   // a frame error when 0 < n < DATA_W, and nothing when empty. The output
   // slot holds one word; a word arriving at a full, unpopped slot is lost.
   logic [DATA_W-1:0] exp_q[$];
   logic [DATA_W-1:0] m_slot = '0;
   logic              m_full = 1'b0;
   int                exp_ovr  = 0;
   int                exp_ferr = 0;

   function automatic void model_frame(input logic [31:0] pat, input int n,
                                       input bit ready_at_load, input bit pop_after);
      logic [DATA_W-1:0] w;
      if (n >= DATA_W) begin
         w = DATA_W'(pat >> (n - DATA_W));
         if (!m_full) begin
            m_slot = w;
            m_full = 1'b1;
         end else if (ready_at_load) begin
            exp_q.push_back(m_slot);
            m_slot = w;
         end else begin
            exp_ovr++;
         end
      end else if (n > 0) begin
         exp_ferr++;
      end
      if (pop_after && m_full) begin
         exp_q.push_back(m_slot);
         m_full = 1'b0;
      end
   endfunction

   function automatic void model_pop();
      if (m_full) begin
         exp_q.push_back(m_slot);
         m_full = 1'b0;
      end
   endfunction

   // ---------------- scoreboard ----------------
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic compare_queues(input string tag);
      int n;
      check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
      n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) begin
         check($sformatf("%s_word%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
      end
      check({tag, "_ferr"}, 32'(mon_ferr), 32'(exp_ferr));
      check({tag, "_ovr"}, 32'(mon_ovr), 32'(exp_ovr));
      got_q.delete();
      exp_q.delete();
   endtask

   // ---------------- driver tasks ----------------
   task automatic hold(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_bits(input logic [31:0] pat, input int n);
      for (int i = n - 1; i >= 0; i--) begin
         mosi = pat[i];
         hold(HALF);
         sclk = 1'b1;
         hold(HALF);
         sclk = 1'b0;
      end
   endtask

   task automatic frame(input logic [31:0] pat, input int n);
      cs_n = 1'b0;
      hold(HALF);
      send_bits(pat, n);
      hold(HALF);
      cs_n = 1'b1;
      hold(2 * HALF);
   endtask

   // Watchdog so the bench always terminates.
   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

   // ---------------- directed + random sequence ----------------
   initial begin
      int lat;
      logic [31:0] pat;
      int n;

      rst = 1'b1; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0; dout_ready = 1'b0;
      hold(3);
      @(negedge clk);
      check("rst_dout",      32'(dout),       32'h0);
      check("rst_valid",     32'(dout_valid), 32'h0);
      check("rst_overrun",   32'(overrun),    32'h0);
      check("rst_frame_err", 32'(frame_err),  32'h0);
      check("rst_state",     32'(dbg_state),  32'(ST_IDLE));
      hold(1);
      rst = 1'b0;
      hold(6);

      // Nominal frame with latency measurement on the final bit.
      dout_ready = 1'b1;
      cs_n = 1'b0;
      hold(HALF);
      send_bits(32'h0F5 >> 1, DATA_W - 1);
      mosi = 1'b1;  // LSB of 12'h0F5
      hold(HALF);
      sclk = 1'b1;
      hold(1);  // first clk edge sampling sclk high
      lat = 0;
      while (!dout_valid && lat < 20) begin
         hold(1);
         lat++;
      end
      check("nom_latency", 32'(lat), 32'(SYNC + 2));
      check("nom_dout", 32'(dout), 32'h0F5);
      sclk = 1'b0;
      hold(HALF);
      cs_n = 1'b1;
      hold(2 * HALF);
      model_frame(32'h0F5, DATA_W, 1'b1, 1'b1);
      compare_queues("nominal");

      // Back-pressure: second word dropped, first held.
      dout_ready = 1'b0;
      frame(32'h0F5, DATA_W);  model_frame(32'h0F5, DATA_W, 1'b0, 1'b0);
      frame(32'hA3C, DATA_W);  model_frame(32'hA3C, DATA_W, 1'b0, 1'b0);
      check("bp_valid", 32'(dout_valid), 32'(m_full));
      check("bp_dout",  32'(dout),       32'(m_slot));
      check("bp_ovr",   32'(mon_ovr),    32'(exp_ovr));
      dout_ready = 1'b1;
      hold(1);
      dout_ready = 1'b0;
      model_pop();
      @(negedge clk);
      check("bp_valid_drop", 32'(dout_valid), 32'(m_full));
      hold(1);
      compare_queues("backpressure");

      // Ready pulsed exactly in the load cycle of the second word.
      frame(32'h0F5, DATA_W);  model_frame(32'h0F5, DATA_W, 1'b0, 1'b0);
      cs_n = 1'b0;
      hold(HALF);
      send_bits(32'hA3C >> 1, DATA_W - 1);
      mosi = 1'b0;  // LSB of 12'hA3C
      hold(HALF);
      sclk = 1'b1;
      hold(SYNC + 2);  // now in the cycle ending with the load edge
      dout_ready = 1'b1;
      hold(1);
      dout_ready = 1'b0;
      model_frame(32'hA3C, DATA_W, 1'b1, 1'b0);
      @(negedge clk);
      check("sim_dout",    32'(dout),       32'(m_slot));
      check("sim_valid",   32'(dout_valid), 32'(m_full));
      check("sim_overrun", 32'(overrun),    32'h0);
      hold(HALF);
      sclk = 1'b0;
      hold(HALF);
      cs_n = 1'b1;
      hold(2 * HALF);
      dout_ready = 1'b1;
      hold(1);
      dout_ready = 1'b0;
      model_pop();
      hold(2);
      compare_queues("simultaneous");

      // Short frame, then a full frame.
      dout_ready = 1'b1;
      frame(32'h55, 7);        model_frame(32'h55, 7, 1'b1, 1'b1);
      check("short_no_valid", 32'(got_q.size()), 32'h0);
      frame(32'h0F5, DATA_W);  model_frame(32'h0F5, DATA_W, 1'b1, 1'b1);
      hold(2);
      compare_queues("short");

      // Extra sclk edges after the word completes.
      frame((32'h0F5 << 3) | 32'h7, 15);
      model_frame((32'h0F5 << 3) | 32'h7, 15, 1'b1, 1'b1);
      hold(2);
      compare_queues("extra");

      // Reset in the middle of a frame.
      cs_n = 1'b0;
      hold(HALF);
      send_bits(32'h0F5 >> 7, 5);
      rst = 1'b1;
      hold(2);
      @(negedge clk);
      check("mid_rst_dout",  32'(dout),       32'h0);
      check("mid_rst_valid", 32'(dout_valid), 32'h0);
      check("mid_rst_ferr",  32'(frame_err),  32'h0);
      hold(1);
      rst = 1'b0;
      m_full = 1'b0;
      send_bits(32'h0F5 & 32'h7F, 7);
      hold(HALF);
      cs_n = 1'b1;
      hold(2 * HALF);
      compare_queues("mid_rst_tail");
      frame(32'h0F5, DATA_W);  model_frame(32'h0F5, DATA_W, 1'b1, 1'b1);
      hold(2);
      compare_queues("after_rst");

      // Randomized frames of varied length and content.
      for (int k = 0; k < 24; k++) begin
         pat = $urandom;
         n   = $urandom_range(0, 16);
         frame(pat, n);
         model_frame(pat, n, 1'b1, 1'b1);
      end
      hold(4);
      compare_queues("random");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_spi_slave_rx
